// File: rtl/interlayer_act_pingpong_buffer.sv
// Ping-pong activation store: producer fills one bank while the consumer streams the
// other LOOPS times; a side port returns words of the most recently completed bank.
module interlayer_act_pingpong_buffer #(
  parameter int PREC     = 16,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4,
  parameter int DEPTH    = 64,
  parameter int ID_WIDTH = 6,
  parameter int LOOPS    = 4,
  parameter int OUT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [N_IN*ID_WIDTH-1:0] wr_id_i,
  input  logic [N_IN*PREC-1:0]     wr_data_i,
  input  logic                     start_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [N_OUT*PREC-1:0]    rd_data_o,
  output logic                     rd_last_o,
  output logic                     rd_done_o,
  input  logic [ID_WIDTH-1:0]      b_ptr_i,
  output logic [PREC-1:0]          b_act_o,
  output logic                     overflow_o
);
  localparam int STEP = (OUT_MODE == 1) ? N_OUT : 1;
  localparam int LCW  = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [ID_WIDTH-1:0] PTR_END  = ID_WIDTH'(DEPTH - STEP);
  localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(DEPTH - 1);
  localparam logic [LCW-1:0]      LOOP_END = LCW'(LOOPS - 1);

  typedef enum logic [1:0] {IDLE, READ, RELEASE} state_e;
  state_e state_q, state_d;

  logic [PREC-1:0]        mem_q [2][DEPTH];
  logic [1:0]             bank_full_q, bank_full_d;
  logic                   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                   last_bank_q, last_bank_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic [LCW-1:0]         loop_q, loop_d;
  logic                   rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [N_OUT*PREC-1:0]  rd_data_q, rd_data_d, lanes;
  logic                   overflow_q, overflow_d;
  logic [PREC-1:0]        b_act_q;
  logic                   wr_fire, wr_complete, end_pass, final_beat;
  logic                   launch, issue, release_bank;

  // Gated by rst so every output reads 0 while reset is held.
  assign wr_ready_o  = !rst && !bank_full_q[wr_bank_q];
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_complete = wr_fire && (wr_id_i[(N_IN-1)*ID_WIDTH +: ID_WIDTH] == ID_LAST);
  assign end_pass    = (ptr_q == PTR_END);
  assign final_beat  = end_pass && (loop_q == LOOP_END);

  always_ff @(posedge clk) begin
    if (wr_fire)
      for (int i = 0; i < N_IN; i++)
        mem_q[wr_bank_q][wr_id_i[i*ID_WIDTH +: ID_WIDTH]] <= wr_data_i[i*PREC +: PREC];
  end

  always_comb begin
    lanes = '0;
    for (int j = 0; j < N_OUT; j++)
      lanes[j*PREC +: PREC] = (OUT_MODE == 1) ? mem_q[rd_bank_q][ptr_q + ID_WIDTH'(j)]
                                              : mem_q[rd_bank_q][ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = READ;
      READ:    if (issue && final_beat) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch       = (state_q == IDLE) && start_i && bank_full_q[rd_bank_q];
    issue        = (state_q == READ) && (!rd_valid_q || rd_ready_i);
    release_bank = (state_q == RELEASE);
    rd_done_o    = release_bank && !rst;
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    last_bank_d = last_bank_q;
    ptr_d       = ptr_q;
    loop_d      = loop_q;
    rd_valid_d  = rd_valid_q && !rd_ready_i;
    rd_last_d   = rd_last_q && rd_valid_d;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q || (wr_valid_i && !wr_ready_o);
    // Set and clear always hit different banks, so both apply in the same cycle.
    if (wr_complete) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = !wr_bank_q;
      last_bank_d            = wr_bank_q;
    end
    if (release_bank) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = !rd_bank_q;
    end
    if (launch) begin
      ptr_d  = '0;
      loop_d = '0;
    end
    if (issue) begin
      rd_valid_d = 1'b1;
      rd_data_d  = lanes;
      rd_last_d  = final_beat;
      if (end_pass) begin
        ptr_d  = '0;
        loop_d = loop_q + LCW'(1);
      end else begin
        ptr_d  = ptr_q + ID_WIDTH'(STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      last_bank_q <= 1'b0;
      ptr_q       <= '0;
      loop_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      b_act_q     <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      last_bank_q <= last_bank_d;
      ptr_q       <= ptr_d;
      loop_q      <= loop_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      b_act_q     <= mem_q[last_bank_q][b_ptr_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign overflow_o = overflow_q;
  assign b_act_o    = b_act_q;
endmodule

// File: tb/tb_interlayer_act_pingpong_buffer.sv
// Randomized bench: instance 0 broadcasts (LOOPS=4), instance 1 stripes (LOOPS=2);
// expected beats come from per-fill bank images and the lane/loop rules.
module tb_interlayer_act_pingpong_buffer;
  localparam int PREC = 16, N_IN = 4, N_OUT = 4, DEPTH = 64, IDW = 6;
  localparam int G = DEPTH / N_IN;
  localparam int LOOPS0 = 4, LOOPS1 = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_valid [2];
  logic start [2];
  logic [N_IN*IDW-1:0]   wr_id = '0;
  logic [N_IN*PREC-1:0]  wr_data = '0;
  logic                  rd_ready = 1'b0;
  logic [IDW-1:0]        b_ptr = '0;
  logic                  wr_ready [2], rd_valid [2], rd_last [2], rd_done [2], overflow [2];
  logic [N_OUT*PREC-1:0] rd_data [2];
  logic [PREC-1:0]       b_act [2];
  logic [PREC-1:0]       imgs [8][DEPTH];
  int n_chk = 0, n_pass = 0;
  bit fdone;

  always #5 clk = !clk;

  interlayer_act_pingpong_buffer #(.PREC(PREC), .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH),
    .ID_WIDTH(IDW), .LOOPS(LOOPS0), .OUT_MODE(0)) u_bcast (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid[0]), .wr_ready_o(wr_ready[0]),
    .wr_id_i(wr_id), .wr_data_i(wr_data), .start_i(start[0]), .rd_valid_o(rd_valid[0]),
    .rd_ready_i(rd_ready), .rd_data_o(rd_data[0]), .rd_last_o(rd_last[0]),
    .rd_done_o(rd_done[0]), .b_ptr_i(b_ptr), .b_act_o(b_act[0]), .overflow_o(overflow[0]));

  interlayer_act_pingpong_buffer #(.PREC(PREC), .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH),
    .ID_WIDTH(IDW), .LOOPS(LOOPS1), .OUT_MODE(1)) u_stripe (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid[1]), .wr_ready_o(wr_ready[1]),
    .wr_id_i(wr_id), .wr_data_i(wr_data), .start_i(start[1]), .rd_valid_o(rd_valid[1]),
    .rd_ready_i(rd_ready), .rd_data_o(rd_data[1]), .rd_last_o(rd_last[1]),
    .rd_done_o(rd_done[1]), .b_ptr_i(b_ptr), .b_act_o(b_act[1]), .overflow_o(overflow[1]));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic gen(input int slot, input int kind);
    for (int k = 0; k < DEPTH; k++)
      case (kind)
        0:       imgs[slot][k] = PREC'(k);
        1:       imgs[slot][k] = PREC'(3 * k);
        default: imgs[slot][k] = PREC'($urandom);
      endcase
  endtask

  // Expected beat k of a bank read: broadcast repeats word[k mod DEPTH] on every lane,
  // striped shows N_OUT consecutive words starting at (k mod beats_per_pass)*N_OUT.
  function automatic logic [63:0] exp_beat(input int sel, input int slot, input int k);
    logic [N_OUT*PREC-1:0] v;
    int b;
    b = (sel == 0) ? (k % DEPTH) : (k % (DEPTH / N_OUT)) * N_OUT;
    for (int j = 0; j < N_OUT; j++) v[j*PREC +: PREC] = imgs[slot][(sel == 0) ? b : b + j];
    return 64'(v);
  endfunction

  // Called and returns at posedge+1; honours wr_ready so overflow never fires.
  task automatic fill(input int sel, input int slot, input int ngroups);
    int waitc;
    for (int g = 0; g < ngroups; g++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      waitc = 0;
      while (!wr_ready[sel]) begin
        @(posedge clk); #1;
        waitc++;
        if (waitc > 4000) begin check("wr_ready_timeout", 64'(0), 64'(1)); return; end
      end
      for (int i = 0; i < N_IN; i++) begin
        wr_id[i*IDW +: IDW]     = IDW'(g * N_IN + i);
        wr_data[i*PREC +: PREC] = imgs[slot][g * N_IN + i];
      end
      wr_valid[sel] = 1'b1;
      @(posedge clk); #1;
      wr_valid[sel] = 1'b0;
    end
  endtask

  task automatic rd_bank(input int sel, input int slot, input bit rnd, input int abort_at);
    int nb, k, cyc;
    bit seen_last, acc;
    nb = (sel == 0) ? LOOPS0 * DEPTH : LOOPS1 * DEPTH / N_OUT;
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    k = 0; cyc = 0; seen_last = 0;
    while (k < nb) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check("rd_valid", 64'(rd_valid[sel]), 64'(cyc >= 1));
      if (cyc >= 1) begin
        check("rd_data", 64'(rd_data[sel]), exp_beat(sel, slot, k));
        check("rd_last", 64'(rd_last[sel]), 64'(k == nb - 1));
      end
      check("rd_done", 64'(rd_done[sel]), 64'(cyc >= 1 && k == nb - 1 && !seen_last));
      if (cyc >= 1 && k == nb - 1) seen_last = 1;
      acc = (cyc >= 1) && rd_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k == abort_at) return;
      end
      if (cyc > 8 * nb + 16) begin check("rd_timeout", 64'(k), 64'(nb)); return; end
    end
    @(negedge clk);
    check("rd_valid_drop", 64'(rd_valid[sel]), 64'(0));
    check("rd_done_once", 64'(rd_done[sel]), 64'(0));
    @(posedge clk); #1;
  endtask

  // Both banks full: wr_ready must stay low until the read bank is released.
  task automatic release_watch(input int sel);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rd_done[sel]) break;
      check("wr_ready_full", 64'(wr_ready[sel]), 64'(0));
      n++;
      if (n > 4000) begin check("release_timeout", 64'(0), 64'(1)); break; end
    end
    @(negedge clk);
    check("wr_ready_freed", 64'(wr_ready[sel]), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_rd_valid"}, 64'(rd_valid[d]), 64'(0));
      check({tag, "_wr_ready"}, 64'(wr_ready[d]), 64'(1));
      check({tag, "_rd_last"},  64'(rd_last[d]),  64'(0));
      check({tag, "_rd_done"},  64'(rd_done[d]),  64'(0));
      check({tag, "_overflow"}, 64'(overflow[d]), 64'(0));
      check({tag, "_b_act"},    64'(b_act[d]),    64'(0));
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    wr_valid[0] = 1'b0; wr_valid[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("por");
    @(posedge clk); #1;

    // Broadcast, always ready; then striped, ready then random.
    gen(0, 0); fill(0, 0, G); rd_bank(0, 0, 0, -1);
    gen(1, 0); fill(1, 1, G); rd_bank(1, 1, 0, -1);
    gen(2, 2); fill(1, 2, G); rd_bank(1, 2, 1, -1);

    // Ping-pong on the broadcast instance with random back-pressure.
    gen(3, 2); gen(4, 2); gen(5, 2);
    fill(0, 3, G);
    fork
      rd_bank(0, 3, 1, -1);
      begin fill(0, 4, G); release_watch(0); fill(0, 5, G); end
    join
    @(negedge clk);
    check("overflow_honoured", 64'(overflow[0]), 64'(0));
    @(posedge clk); #1;
    rd_bank(0, 4, 1, -1);
    rd_bank(0, 5, 0, -1);

    // Backward-pass port.
    pulse_rst();
    gen(6, 1); gen(7, 2);
    fill(0, 6, G);
    b_ptr = IDW'(10);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_act_10", 64'(b_act[0]), 64'(30));
    @(posedge clk); #1;
    fdone = 0;
    fork
      begin fill(0, 7, G); fdone = 1; end
      begin
        while (!fdone) begin
          @(negedge clk);
          check("b_act_hold", 64'(b_act[0]), 64'(30));
        end
      end
    join
    @(posedge clk);
    @(negedge clk);
    check("b_act_next_bank", 64'(b_act[0]), 64'(imgs[7][10]));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      p = $urandom_range(0, DEPTH - 1);
      b_ptr = IDW'(p);
      @(posedge clk);
      @(negedge clk);
      check("b_act_rand", 64'(b_act[0]), 64'(imgs[7][p]));
    end
    @(posedge clk); #1;

    // Both banks full: a write that ignores wr_ready is dropped and flagged.
    @(negedge clk);
    check("wr_ready_both_full", 64'(wr_ready[0]), 64'(0));
    check("overflow_before", 64'(overflow[0]), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < N_IN; i++) begin
      wr_id[i*IDW +: IDW]     = IDW'(DEPTH - N_IN + i);
      wr_data[i*PREC +: PREC] = 16'hdead;
    end
    wr_valid[0] = 1'b1;
    @(posedge clk); #1;
    wr_valid[0] = 1'b0;
    @(negedge clk);
    check("overflow_set", 64'(overflow[0]), 64'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("overflow_sticky", 64'(overflow[0]), 64'(1));
    @(posedge clk); #1;
    rd_bank(0, 6, 0, -1);

    // Reset in the middle of a read and a fill.
    pulse_rst();
    fill(0, 0, G);
    fork
      rd_bank(0, 0, 1, 37);
      fill(0, 2, 8);
    join
    pulse_rst();
    @(negedge clk);
    reset_checks("mid");
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("empty_no_read", 64'(rd_valid[0]), 64'(0));
    end
    @(posedge clk); #1;
    fill(0, 0, G); rd_bank(0, 0, 0, -1);
    fill(0, 3, G); rd_bank(0, 3, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
